// File: rtl/reg_arb_pkg.sv
// Shared types and constants for the register-access arbiter.
// Holds the FSM state encoding and the default read data returned on an ack timeout.
package reg_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hdead_1eaf;

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority picker: the first set request at or after (last+1) mod N_REQ, wrapping around.
// Purely combinational, so it adds no latency; it has no handshake and applies no backpressure.
module rr_pick #(
  parameter int N_REQ = 2,
  parameter int GW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [GW-1:0]    i_last,
  output logic [GW-1:0]    o_grant,
  output logic             o_any
);

  logic [GW-1:0] w_idx;

  // Walk from the farthest offset down to the nearest, so the nearest match is the one that sticks.
  always_comb begin
    o_any   = 1'b0;
    o_grant = '0;
    w_idx   = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      w_idx = GW'((int'(i_last) + k) % N_REQ);
      if (i_req[w_idx]) begin
        o_any   = 1'b1;
        o_grant = w_idx;
      end
    end
  end

endmodule

// File: rtl/reg_access_arb.sv
// Round-robin arbiter that shares one downstream register port among N_REQ masters, with an ack timeout.
// Request-to-ack takes at least 2 cycles; other masters wait (no preemption) and a timeout returns an error response.
module reg_access_arb
  import reg_arb_pkg::*;
#(
  parameter int          ADDR_WIDTH = 64,
  parameter int          DATA_WIDTH = 32,
  parameter int          N_REQ      = 2,
  parameter int          TIMECNT    = 99,
  parameter logic [31:0] ERR_DATA   = ERR_DATA_DEFAULT
) (
  input  logic                          PCLK,
  input  logic                          PRESETn,
  input  logic [N_REQ-1:0]              up__arb__req_vld,
  input  logic [N_REQ*ADDR_WIDTH-1:0]   up__arb__addr,
  input  logic [N_REQ-1:0]              up__arb__wr_en,
  input  logic [N_REQ-1:0]              up__arb__rd_en,
  input  logic [N_REQ*DATA_WIDTH-1:0]   up__arb__wr_data,
  output logic [N_REQ-1:0]              arb__up__ack_vld,
  output logic [N_REQ-1:0]              arb__up__err,
  output logic [DATA_WIDTH-1:0]         arb__up__rd_data,
  output logic                          arb__slv__req_vld,
  output logic [ADDR_WIDTH-1:0]         arb__slv__addr,
  output logic                          arb__slv__wr_en,
  output logic                          arb__slv__rd_en,
  output logic [DATA_WIDTH-1:0]         arb__slv__wr_data,
  input  logic                          slv__arb__ack_vld,
  input  logic [DATA_WIDTH-1:0]         slv__arb__rd_data,
  output logic                          arb__slv__sync_reset,
  output logic [$clog2(N_REQ)-1:0]      grant_id,
  input  logic                          clear,
  output logic                          interrupt,
  output logic [ADDR_WIDTH-1:0]         timeout_addr
);

  localparam int                    GW         = $clog2(N_REQ);
  localparam int                    CW         = $clog2(TIMECNT + 1);
  localparam logic [DATA_WIDTH-1:0] ERR_DATA_W = DATA_WIDTH'(ERR_DATA);

  arb_state_e              r_state, w_state_nxt;
  logic [CW-1:0]           r_cnt, w_cnt_nxt;
  logic [GW-1:0]           r_last, w_last_nxt;
  logic [GW-1:0]           r_grant, w_grant_nxt;
  logic [N_REQ-1:0]        r_ack, w_ack_nxt;
  logic [N_REQ-1:0]        r_err, w_err_nxt;
  logic [DATA_WIDTH-1:0]   r_rd_data, w_rd_data_nxt;
  logic                    r_slv_req, w_slv_req_nxt;
  logic [ADDR_WIDTH-1:0]   r_slv_addr, w_slv_addr_nxt;
  logic                    r_slv_wr, w_slv_wr_nxt;
  logic                    r_slv_rd, w_slv_rd_nxt;
  logic [DATA_WIDTH-1:0]   r_slv_wdata, w_slv_wdata_nxt;
  logic                    r_sync_rst, w_sync_rst_nxt;
  logic                    r_irq, w_irq_nxt;
  logic [ADDR_WIDTH-1:0]   r_to_addr, w_to_addr_nxt;

  logic [GW-1:0]           w_pick;
  logic                    w_any;

  rr_pick #(
    .N_REQ (N_REQ),
    .GW    (GW)
  ) u_pick (
    .i_req   (up__arb__req_vld),
    .i_last  (r_last),
    .o_grant (w_pick),
    .o_any   (w_any)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_last_nxt      = r_last;
    w_grant_nxt     = r_grant;
    w_ack_nxt       = '0;
    w_err_nxt       = '0;
    w_rd_data_nxt   = r_rd_data;
    w_slv_req_nxt   = r_slv_req;
    w_slv_addr_nxt  = r_slv_addr;
    w_slv_wr_nxt    = r_slv_wr;
    w_slv_rd_nxt    = r_slv_rd;
    w_slv_wdata_nxt = r_slv_wdata;
    w_sync_rst_nxt  = 1'b0;
    w_irq_nxt       = r_irq;
    w_to_addr_nxt   = r_to_addr;

    // The timeout branch below overrides this, so a timeout beats a simultaneous clear.
    if (clear) begin
      w_irq_nxt     = 1'b0;
      w_to_addr_nxt = '0;
    end

    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_grant_nxt     = w_pick;
          w_slv_req_nxt   = 1'b1;
          w_slv_addr_nxt  = up__arb__addr[int'(w_pick)*ADDR_WIDTH +: ADDR_WIDTH];
          w_slv_wr_nxt    = up__arb__wr_en[w_pick];
          w_slv_rd_nxt    = up__arb__rd_en[w_pick] & ~up__arb__wr_en[w_pick];
          w_slv_wdata_nxt = up__arb__wr_data[int'(w_pick)*DATA_WIDTH +: DATA_WIDTH];
          w_cnt_nxt       = CW'(1);
          w_state_nxt     = BUSY;
        end
      end
      BUSY: begin
        if (slv__arb__ack_vld || (r_cnt == CW'(TIMECNT))) begin
          w_ack_nxt[r_grant] = 1'b1;
          w_slv_req_nxt      = 1'b0;
          w_slv_wr_nxt       = 1'b0;
          w_slv_rd_nxt       = 1'b0;
          w_state_nxt        = RESP;
          if (slv__arb__ack_vld) begin
            w_rd_data_nxt = slv__arb__rd_data;
          end else begin
            w_err_nxt[r_grant] = 1'b1;
            w_rd_data_nxt      = ERR_DATA_W;
            w_sync_rst_nxt     = 1'b1;
            w_irq_nxt          = 1'b1;
            w_to_addr_nxt      = r_slv_addr;
          end
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      RESP: begin
        w_last_nxt  = r_grant;
        w_cnt_nxt   = '0;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_cnt       <= '0;
      r_last      <= GW'(N_REQ - 1);
      r_grant     <= '0;
      r_ack       <= '0;
      r_err       <= '0;
      r_rd_data   <= '0;
      r_slv_req   <= 1'b0;
      r_slv_addr  <= '0;
      r_slv_wr    <= 1'b0;
      r_slv_rd    <= 1'b0;
      r_slv_wdata <= '0;
      r_sync_rst  <= 1'b0;
      r_irq       <= 1'b0;
      r_to_addr   <= '0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_last      <= w_last_nxt;
      r_grant     <= w_grant_nxt;
      r_ack       <= w_ack_nxt;
      r_err       <= w_err_nxt;
      r_rd_data   <= w_rd_data_nxt;
      r_slv_req   <= w_slv_req_nxt;
      r_slv_addr  <= w_slv_addr_nxt;
      r_slv_wr    <= w_slv_wr_nxt;
      r_slv_rd    <= w_slv_rd_nxt;
      r_slv_wdata <= w_slv_wdata_nxt;
      r_sync_rst  <= w_sync_rst_nxt;
      r_irq       <= w_irq_nxt;
      r_to_addr   <= w_to_addr_nxt;
    end
  end

  assign arb__up__ack_vld     = r_ack;
  assign arb__up__err         = r_err;
  assign arb__up__rd_data     = r_rd_data;
  assign arb__slv__req_vld    = r_slv_req;
  assign arb__slv__addr       = r_slv_addr;
  assign arb__slv__wr_en      = r_slv_wr;
  assign arb__slv__rd_en      = r_slv_rd;
  assign arb__slv__wr_data    = r_slv_wdata;
  assign arb__slv__sync_reset = r_sync_rst;
  assign grant_id             = r_grant;
  assign interrupt            = r_irq;
  assign timeout_addr         = r_to_addr;

endmodule

// File: tb/tb_reg_access_arb.sv
// Directed bench for reg_access_arb: a table of single-master transactions plus hand-written
// sequences for round-robin fairness, clear, and reset in the middle of a transaction.
module tb_reg_access_arb;

  localparam int AW = 64;
  localparam int DW = 32;
  localparam int N  = 2;
  localparam int TC = 99;

  logic              PCLK = 1'b0;
  logic              PRESETn = 1'b0;
  logic [N-1:0]      req_vld = '0;
  logic [N*AW-1:0]   addr = '0;
  logic [N-1:0]      wr_en = '0;
  logic [N-1:0]      rd_en = '0;
  logic [N*DW-1:0]   wdata = '0;
  logic [N-1:0]      ack_vld;
  logic [N-1:0]      err;
  logic [DW-1:0]     rd_data;
  logic              slv_req;
  logic [AW-1:0]     slv_addr;
  logic              slv_wr;
  logic              slv_rd;
  logic [DW-1:0]     slv_wdata;
  logic              slv_ack = 1'b0;
  logic [DW-1:0]     slv_rdata = '0;
  logic              sync_reset;
  logic [0:0]        grant_id;
  logic              clear = 1'b0;
  logic              interrupt;
  logic [AW-1:0]     timeout_addr;

  int n_checks = 0;
  int n_errors = 0;

  always #5 PCLK = ~PCLK;

  reg_access_arb #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .N_REQ      (N),
    .TIMECNT    (TC)
  ) dut (
    .PCLK                 (PCLK),
    .PRESETn              (PRESETn),
    .up__arb__req_vld     (req_vld),
    .up__arb__addr        (addr),
    .up__arb__wr_en       (wr_en),
    .up__arb__rd_en       (rd_en),
    .up__arb__wr_data     (wdata),
    .arb__up__ack_vld     (ack_vld),
    .arb__up__err         (err),
    .arb__up__rd_data     (rd_data),
    .arb__slv__req_vld    (slv_req),
    .arb__slv__addr       (slv_addr),
    .arb__slv__wr_en      (slv_wr),
    .arb__slv__rd_en      (slv_rd),
    .arb__slv__wr_data    (slv_wdata),
    .slv__arb__ack_vld    (slv_ack),
    .slv__arb__rd_data    (slv_rdata),
    .arb__slv__sync_reset (sync_reset),
    .grant_id             (grant_id),
    .clear                (clear),
    .interrupt            (interrupt),
    .timeout_addr         (timeout_addr)
  );

  typedef struct {
    int          m;
    logic        wr;
    logic        rd;
    logic [63:0] a;
    logic [31:0] wd;
    int          k;      // BUSY cycle in which the slave acks; 0 = never
    logic [31:0] srd;
    logic        e_wr;
    logic        e_rd;
    logic        e_err;
    logic [31:0] e_rdata;
    int          e_lat;
    logic        e_sync;
    logic        e_irq;
    logic [63:0] e_toaddr;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic do_reset();
    PRESETn = 1'b0;
    req_vld = '0; wr_en = '0; rd_en = '0; addr = '0; wdata = '0;
    slv_ack = 1'b0; slv_rdata = '0; clear = 1'b0;
    repeat (2) tick();
    PRESETn = 1'b1;
    tick();
  endtask

  task automatic run_txn(input int idx, input vec_t v);
    int            lat;
    logic [N-1:0]  ackv, errv, exp_ack, exp_err;
    logic [31:0]   rdd, swd;
    logic [63:0]   sa;
    logic          sw, sr, sync;
    lat = 0; ackv = 'x; errv = 'x; rdd = 'x; swd = 'x; sa = 'x; sw = 1'bx; sr = 1'bx; sync = 1'bx;
    req_vld[v.m] = 1'b1;
    wr_en[v.m]   = v.wr;
    rd_en[v.m]   = v.rd;
    addr[v.m*AW +: AW]  = v.a;
    wdata[v.m*DW +: DW] = v.wd;
    for (int c = 1; c <= TC + 20; c++) begin
      tick();
      slv_ack = 1'b0;
      if (c == 1) begin
        sa = slv_addr; sw = slv_wr; sr = slv_rd; swd = slv_wdata;
      end
      if (ack_vld != '0) begin
        lat = c; ackv = ack_vld; errv = err; rdd = rd_data; sync = sync_reset;
        break;
      end
      if (c == v.k) begin
        slv_ack   = 1'b1;
        slv_rdata = v.srd;
      end
    end
    req_vld[v.m] = 1'b0;
    wr_en[v.m]   = 1'b0;
    rd_en[v.m]   = 1'b0;
    exp_ack = '0; exp_ack[v.m] = 1'b1;
    exp_err = '0; exp_err[v.m] = v.e_err;
    chk($sformatf("v%0d_latency", idx), 64'(lat), 64'(v.e_lat));
    chk($sformatf("v%0d_slv_addr", idx), sa, v.a);
    chk($sformatf("v%0d_slv_cmd", idx), {62'd0, sw, sr}, {62'd0, v.e_wr, v.e_rd});
    chk($sformatf("v%0d_slv_wdata", idx), 64'(swd), 64'(v.wd));
    chk($sformatf("v%0d_ack_vld", idx), 64'(ackv), 64'(exp_ack));
    chk($sformatf("v%0d_err", idx), 64'(errv), 64'(exp_err));
    chk($sformatf("v%0d_rd_data", idx), 64'(rdd), 64'(v.e_rdata));
    chk($sformatf("v%0d_sync_reset", idx), 64'(sync), 64'(v.e_sync));
    tick();
    chk($sformatf("v%0d_after_resp", idx), {60'd0, ack_vld, sync_reset, slv_req}, 64'd0);
    chk($sformatf("v%0d_interrupt", idx), 64'(interrupt), 64'(v.e_irq));
    chk($sformatf("v%0d_timeout_addr", idx), timeout_addr, v.e_toaddr);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int          gr[4];
    int          ng;
    logic        two_acks, seen_ack, granted;

    //         m  wr rd addr    wdata         k   slave rd       wr rd err rd_data        lat sync irq timeout_addr
    vecs[0] = '{0, 1, 0, 64'h10, 32'hA5,       1,  32'h0,         1, 0, 0, 32'h0,         2,  0, 0, 64'h0};
    vecs[1] = '{1, 0, 1, 64'h20, 32'h0,        5,  32'h1234_5678, 0, 1, 0, 32'h1234_5678, 6,  0, 0, 64'h0};
    vecs[2] = '{0, 1, 1, 64'h30, 32'h55,       2,  32'h0,         1, 0, 0, 32'h0,         3,  0, 0, 64'h0};
    vecs[3] = '{1, 0, 0, 64'h38, 32'h0,        1,  32'h77,        0, 0, 0, 32'h77,        2,  0, 0, 64'h0};
    vecs[4] = '{0, 0, 1, 64'h40, 32'h0,        0,  32'h0,         0, 1, 1, 32'hdead_1eaf, 100, 1, 1, 64'h40};
    vecs[5] = '{1, 0, 1, 64'h50, 32'h0,        99, 32'hCAFE,      0, 1, 0, 32'hCAFE,      100, 0, 1, 64'h40};

    do_reset();
    chk("rst_ctl", {56'd0, ack_vld, err, slv_req, slv_wr, slv_rd, sync_reset}, 64'd0);
    chk("rst_irq_grant", {62'd0, interrupt, grant_id}, 64'd0);
    chk("rst_slv_addr", slv_addr, 64'd0);
    chk("rst_timeout_addr", timeout_addr, 64'd0);
    chk("rst_data", {rd_data, slv_wdata}, 64'd0);

    for (int i = 0; i < 6; i++) begin
      run_txn(i, vecs[i]);
    end

    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear_interrupt", 64'(interrupt), 64'd0);
    chk("clear_timeout_addr", timeout_addr, 64'd0);

    // Both masters hold requests; each drops only for the cycle after its ack.
    do_reset();
    addr = {64'h200, 64'h100};
    wr_en = 2'b11;
    req_vld = 2'b11;
    ng = 0;
    two_acks = 1'b0;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      tick();
      slv_ack = slv_req;
      if (ack_vld != '0) begin
        if (ack_vld == 2'b11) two_acks = 1'b1;
        for (int m = 0; m < N; m++) begin
          if (ack_vld[m]) begin
            if (ng < 4) gr[ng] = m;
            ng++;
            req_vld[m] = 1'b0;
          end
        end
      end else begin
        req_vld = 2'b11;
      end
    end
    slv_ack = 1'b0;
    chk("rr_grant_count", 64'(ng), 64'd4);
    chk("rr_both_acked", 64'(two_acks), 64'd0);
    chk("rr_order", {gr[0][15:0], gr[1][15:0], gr[2][15:0], gr[3][15:0]},
        {16'd0, 16'd1, 16'd0, 16'd1});

    // Reset while master 1 is stuck in BUSY, then both masters request.
    do_reset();
    addr = {64'h60, 64'h70};
    rd_en = 2'b10;
    req_vld = 2'b10;
    repeat (3) tick();
    chk("midrst_busy_grant", {62'd0, slv_req, grant_id}, {62'd0, 1'b1, 1'b1});
    PRESETn = 1'b0;
    #1;
    chk("midrst_ctl", {56'd0, ack_vld, err, slv_req, slv_wr, slv_rd, sync_reset}, 64'd0);
    chk("midrst_addr", slv_addr, 64'd0);
    chk("midrst_grant", 64'(grant_id), 64'd0);
    req_vld = 2'b11;
    wr_en = 2'b01;
    repeat (2) tick();
    PRESETn = 1'b1;
    seen_ack = 1'b0;
    granted = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (ack_vld != '0) seen_ack = 1'b1;
      if (slv_req) begin
        granted = 1'b1;
        break;
      end
    end
    chk("postrst_granted", 64'(granted), 64'd1);
    chk("postrst_no_ack", 64'(seen_ack), 64'd0);
    chk("postrst_first_grant", 64'(grant_id), 64'd0);
    chk("postrst_slv_addr", slv_addr, 64'h70);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/reg_access_arb.md
# reg_access_arb

Round-robin arbiter that shares one downstream register-access port (req/ack handshake, addr, wr/rd enables, write data, read data) among N_REQ upstream masters, such as APB front-end FSMs and debug or DMA masters. It serialises transactions, returns the response and read data to the granted master, and enforces a per-transaction ack timeout with error response, slave sync-reset pulse and sticky interrupt. It sits between the bus-protocol front ends and the register decode/dispatch tree.

## Interface
- ADDR_WIDTH, 64, address width
- DATA_WIDTH, 32, data width
- N_REQ, 2, number of upstream masters (legal 2..8)
- TIMECNT, 99, max BUSY cycles waiting for slave ack
- ERR_DATA, 32'hdead_1eaf, read data returned on timeout (truncated/zero-extended to DATA_WIDTH)

Ports:
- PCLK  in  1  clock
- PRESETn  in  1  reset; asynchronous, active-low
- up__arb__req_vld  in  N_REQ  per-master request level
- up__arb__addr  in  N_REQ*ADDR_WIDTH  packed addresses, master i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- up__arb__wr_en  in  N_REQ  per-master write
- up__arb__rd_en  in  N_REQ  per-master read
- up__arb__wr_data  in  N_REQ*DATA_WIDTH  packed write data
- arb__up__ack_vld  out  N_REQ  one-cycle response pulse to granted master
- arb__up__err  out  N_REQ  timeout error, valid with ack_vld
- arb__up__rd_data  out  DATA_WIDTH  shared read data, valid with ack_vld
- arb__slv__req_vld  out  1  downstream request
- arb__slv__addr  out  ADDR_WIDTH  downstream address
- arb__slv__wr_en / arb__slv__rd_en  out  1 each  downstream command
- arb__slv__wr_data  out  DATA_WIDTH  downstream write data
- slv__arb__ack_vld  in  1  downstream ack
- slv__arb__rd_data  in  DATA_WIDTH  downstream read data, valid with ack
- arb__slv__sync_reset  out  1  one-cycle pulse on timeout
- grant_id  out  $clog2(N_REQ)  currently/last granted master
- clear  in  1  clears interrupt and timeout_addr
- interrupt  out  1  sticky timeout flag
- timeout_addr  out  ADDR_WIDTH  address of last timed-out access

## Operation
- All outputs registered; reset value 0 for every output, FSM state IDLE, cnt 0, last pointer N_REQ-1.
- Masters hold req_vld and command stable from assertion until they sample ack_vld, then drop req_vld.
- FSM states: IDLE, BUSY, RESP.
  - IDLE, any req_vld set: winner = first set bit searching from (last+1) mod N_REQ upward with wrap. Latch winner's addr, wr_en, rd_en and wr_data into arb__slv__*. Set grant_id and arb__slv__req_vld=1. Go to BUSY.
  - BUSY: req_vld and command held. cnt counts BUSY cycles starting at 1.
    - slv__arb__ack_vld=1: capture rd_data, go to RESP with err=0.
    - Else cnt==TIMECNT: go to RESP with err=1, rd_data=ERR_DATA.
    - Ack and timeout in the same cycle: ack wins.
  - RESP: arb__slv__req_vld=0, wr_en and rd_en 0. Assert ack_vld[grant_id] and err[grant_id] for exactly one cycle, with rd_data. On error, also pulse sync_reset and set interrupt and timeout_addr. Set last=grant_id. Go to IDLE.
- wr_en and rd_en both set: write wins and rd_en is forwarded as 0. Neither set: forwarded unchanged.
- Requests arriving in BUSY or RESP wait; there is no preemption.
- interrupt/timeout_addr: timeout sets them, clear zeroes them; timeout wins over a simultaneous clear.
- arb__up__rd_data holds its value outside RESP and is meaningful only with ack_vld.
- PRESETn asserted mid-transaction: immediate return to reset values; the in-flight access is abandoned with no ack.

## Timing
- Request sampled at cycle 0 (IDLE) → arb__slv__req_vld high from cycle 1.
- Slave ack at cycle k≥1 → ack_vld in cycle k+1 → IDLE in cycle k+2.
- Minimum latency from req to ack is 2 cycles. Back-to-back grant period is 3 cycles plus slave wait.
- Timeout: no ack in BUSY cycles 1..TIMECNT → RESP in cycle TIMECNT+1.
- Starvation bound: a waiting master is granted within N_REQ-1 other transactions.

## Structure
- Package reg_arb_pkg: state enum (IDLE, BUSY, RESP) and default ERR_DATA constant.
- Sub-module rr_pick: combinational rotate-priority picker (req vector, last pointer → grant index, any).
- Everything else lives in reg_access_arb.

## Test plan
- Master 0 writes addr 0x10, data 0xA5; slave acks in the first BUSY cycle → downstream wr_en=1, addr 0x10; ack_vld[0] pulses 2 cycles after req; err=0.
- Masters 0 and 1 request simultaneously after reset, held continuously → grants 0,1,0,1; no master gets two consecutive grants.
- Master 1 reads; slave returns 0x1234_5678 after 5 cycles → arb__up__rd_data=0x1234_5678 with ack_vld[1]; ack_vld[0] stays 0.
- Slave silent, TIMECNT=99 → ack_vld with err=1 and rd_data 0xdead_1eaf in cycle 100; sync_reset one-cycle pulse; interrupt=1; timeout_addr=request addr. Then clear → interrupt=0, timeout_addr=0.
- Slave acks exactly at cnt==TIMECNT → normal response; err=0; no sync_reset; interrupt unchanged.
- PRESETn pulsed during BUSY for master 1 → all outputs 0 and no ack. With both masters then requesting, master 0 is granted first.
